writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  Writeback stage plus architectural register file of the multi-cycle RV32I core.
//  - Consumes memory-stage load data (mem_i) and the ALU result (y_in).
//  - Sign- or zero-extends sub-word loads (LB/LH/LBU/LHU), selects the writeback source and commits it to x1..x31.
//  - Supplies the rs1/rs2 operands read in decode, and counts retired instructions.
// PARAMETERS
//  WB_STAGE   3'd5   stage_i value at which writeback occurs (MEM is 4)
//  XLEN       32     data width; only 32 is supported
// PORTS
//  clk        in   1    core clock; the single clock of the block
//  reset      in   1    synchronous, active-high reset
//  stage_i    in   3    current pipeline-sequencer stage
//  itype_i    in   5    instruction class (itype.v codes)
//  ir_i       in   32   current instruction word
//  y_in       in   32   ALU result / effective address
//  mem_i      in   32   load data from memory stage; byte 0 is the byte at address y_in
//  pc_i       in   32   PC of current instruction
//  rs1_addr_i in   5    read port A address
//  rs2_addr_i in   5    read port B address
//  rs1_o      out  32   read port A data (combinational)
//  rs2_o      out  32   read port B data (combinational)
//  wb_valid_o out  1    1-cycle pulse on the cycle a commit occurs
//  wb_rd_o    out  5    rd committed (valid with wb_valid_o)
//  wb_data_o  out  32   value committed (valid with wb_valid_o)
//  instret_o  out  64   retired-instruction count
//  bad_load_o out  1    sticky flag: LTYPE with funct3 in {3,6,7} reached WB
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - all 32 registers become 0; wb_valid_o=0, wb_rd_o=0, wb_data_o=0, instret_o=0, bad_load_o=0.
//    - stage_prev_q becomes 0.
//    - reset wins over a simultaneous commit: no write occurs.
//  - Commit strobe: fires on the cycle where stage_i==WB_STAGE && stage_prev_q!=WB_STAGE.
//    - stage_prev_q registers stage_i every cycle.
//    - If stage_i dwells at WB_STAGE for N cycles, exactly one commit occurs.
//  - On the commit strobe:
//    - instret_o increments by 1 for every itype, wrapping 2^64-1 -> 0.
//    - wb_valid_o=1 for one cycle only when the instruction writes rd and rd!=0; otherwise it stays 0.
//  - Writeback source, with rd=ir_i[11:7] and funct3=ir_i[14:12]:
//    - RTYPE / ITYPE (ALU-imm) / LUITYPE / AUIPCTYPE -> y_in
//    - LTYPE:
//      - funct3 0 (LB) -> {{24{mem_i[7]}}, mem_i[7:0]}
//      - funct3 1 (LH) -> {{16{mem_i[15]}}, mem_i[15:0]}
//      - funct3 2 (LW) -> mem_i
//      - funct3 4 (LBU) -> {24'b0, mem_i[7:0]}
//      - funct3 5 (LHU) -> {16'b0, mem_i[15:0]}
//      - funct3 3/6/7 -> no write; set bad_load_o (cleared only by reset)
//    - JALTYPE / JALRTYPE -> pc_i + 4, modulo 2^32
//    - STYPE / BTYPE / any other code -> no write
//  - Register x0: writes are discarded; rs1_o / rs2_o return 0 for address 0.
//  - Read ports:
//    - combinational from the array, no bypass.
//    - a write committed at edge t is visible on reads from t+1 onward.
//  - wb_rd_o / wb_data_o hold their last committed values between pulses.
//  - Misalignment is not checked here; the memory stage owns addressing.
// STRUCTURE
//  - Shared include itype.v: itype codes, LB3..LHU3 funct3 codes, and new `WB_STAGE and `WBSEL_{ALU,MEM,LINK,NONE} codes.
//  - Sub-module load_extend (combinational: funct3 + mem_i -> extended word + illegal flag).
//  - Top level holds the register array, commit-edge detector, instret counter and output registers.
// TESTING
//  1. Reset mid-operation: reset asserted on the commit cycle -> no write, all outputs 0.
//     After release, rs1_o for x5 reads 0.
//  2. LB mem_i=32'h0000_0080 rd=3 -> x3=32'hFFFF_FF80.
//     LBU same data -> 32'h0000_0080; LH mem_i=32'h0000_8001 -> 32'hFFFF_8001.
//  3. RTYPE y_in=32'hDEAD_BEEF rd=0 -> no wb_valid_o, rs1_o(x0)=0, instret +1.
//     Same with rd=7 -> x7=32'hDEAD_BEEF.
//  4. JAL pc_i=32'hFFFF_FFFC rd=1 -> x1=32'h0000_0000 (wrap); STYPE -> no write, instret +1.
//  5. Hold stage_i=5 for 4 cycles on an RTYPE -> exactly one wb_valid_o pulse, instret +1 only.
//  6. LTYPE funct3=3 -> no write, bad_load_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared codes for the writeback stage: instruction classes, load funct3 values,
// the writeback stage number and the writeback source selector.
package writeback_regfile_pkg;

    localparam int XLEN = 32;
    localparam logic [2:0] WB_STAGE = 3'd5;

    localparam logic [4:0] RTYPE     = 5'd0;
    localparam logic [4:0] ITYPE     = 5'd1;
    localparam logic [4:0] LTYPE     = 5'd2;
    localparam logic [4:0] STYPE     = 5'd3;
    localparam logic [4:0] BTYPE     = 5'd4;
    localparam logic [4:0] LUITYPE   = 5'd5;
    localparam logic [4:0] AUIPCTYPE = 5'd6;
    localparam logic [4:0] JALTYPE   = 5'd7;
    localparam logic [4:0] JALRTYPE  = 5'd8;

    localparam logic [2:0] LB3  = 3'd0;
    localparam logic [2:0] LH3  = 3'd1;
    localparam logic [2:0] LW3  = 3'd2;
    localparam logic [2:0] LBU3 = 3'd4;
    localparam logic [2:0] LHU3 = 3'd5;

    typedef enum logic [1:0] {
        WBSEL_NONE = 2'd0,
        WBSEL_ALU  = 2'd1,
        WBSEL_MEM  = 2'd2,
        WBSEL_LINK = 2'd3
    } wbsel_e;

    function automatic wbsel_e wbsel_of(input logic [4:0] itype);
        case (itype)
            RTYPE, ITYPE, LUITYPE, AUIPCTYPE: wbsel_of = WBSEL_ALU;
            LTYPE:                            wbsel_of = WBSEL_MEM;
            JALTYPE, JALRTYPE:                wbsel_of = WBSEL_LINK;
            default:                          wbsel_of = WBSEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/writeback_regfile_load_extend.sv
// Sub-word load extension: picks the low byte/half/word of the load data and
// sign- or zero-extends it; flags funct3 codes that are not legal loads.
module writeback_regfile_load_extend
    import writeback_regfile_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] mem_i,
    output logic [XLEN-1:0] ext_o,
    output logic            illegal_o
);

    always_comb begin
        ext_o     = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            LB3:     ext_o = {{24{mem_i[7]}}, mem_i[7:0]};
            LH3:     ext_o = {{16{mem_i[15]}}, mem_i[15:0]};
            LW3:     ext_o = mem_i;
            LBU3:    ext_o = {24'b0, mem_i[7:0]};
            LHU3:    ext_o = {16'b0, mem_i[15:0]};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage and x0..x31 register file: commits one result per entry into
// the writeback stage, serves two combinational read ports, counts retirements.
module writeback_regfile
    import writeback_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      stage_i,
    input  logic [4:0]      itype_i,
    input  logic [31:0]     ir_i,
    input  logic [31:0]     y_in,
    input  logic [31:0]     mem_i,
    input  logic [31:0]     pc_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [31:0]     rs1_o,
    output logic [31:0]     rs2_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [31:0]     wb_data_o,
    output logic [63:0]     instret_o,
    output logic            bad_load_o
);

    logic [XLEN-1:0] regs_q [32];
    logic [2:0]      stage_prev_q;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [63:0]     instret_q, instret_d;
    logic            bad_load_q, bad_load_d;

    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            commit;
    logic            wr_en;
    wbsel_e          wbsel;
    logic [31:0]     ext_word;
    logic            ext_illegal;
    logic [31:0]     wr_data;
    logic            unused_ir;

    assign rd        = ir_i[11:7];
    assign funct3    = ir_i[14:12];
    assign unused_ir = ^{ir_i[31:15], ir_i[6:0]};

    // A dwell of several cycles in WB must retire only once, so commit on entry.
    assign commit = (stage_i == WB_STAGE) && (stage_prev_q != WB_STAGE);
    assign wbsel  = wbsel_of(itype_i);

    writeback_regfile_load_extend u_load_extend (
        .funct3_i  (funct3),
        .mem_i     (mem_i),
        .ext_o     (ext_word),
        .illegal_o (ext_illegal)
    );

    always_comb begin
        wr_data = '0;
        case (wbsel)
            WBSEL_ALU:  wr_data = y_in;
            WBSEL_MEM:  wr_data = ext_word;
            WBSEL_LINK: wr_data = pc_i + 32'd4;
            default:    wr_data = '0;
        endcase
    end

    assign wr_en = commit && (wbsel != WBSEL_NONE)
                   && !((wbsel == WBSEL_MEM) && ext_illegal)
                   && (rd != 5'd0);

    always_comb begin
        wb_valid_d = wr_en;
        wb_rd_d    = wr_en ? rd : wb_rd_q;
        wb_data_d  = wr_en ? wr_data : wb_data_q;
        instret_d  = commit ? instret_q + 64'd1 : instret_q;
        bad_load_d = bad_load_q || (commit && (wbsel == WBSEL_MEM) && ext_illegal);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_prev_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            instret_q    <= '0;
            bad_load_q   <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            stage_prev_q <= stage_i;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            instret_q    <= instret_d;
            bad_load_q   <= bad_load_d;
            if (wr_en) regs_q[rd] <= wr_data;
        end
    end

    assign rs1_o      = (rs1_addr_i == 5'd0) ? 32'd0 : regs_q[rs1_addr_i];
    assign rs2_o      = (rs2_addr_i == 5'd0) ? 32'd0 : regs_q[rs2_addr_i];
    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign instret_o  = instret_q;
    assign bad_load_o = bad_load_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus random
// traffic, all checked against an array-based model of the architectural state.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_i;
    logic [4:0]  itype_i;
    logic [31:0] ir_i, y_in, mem_i, pc_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic [31:0] rs1_o, rs2_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [63:0] instret_o;
    logic        bad_load_o;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [31:0] m_regs [32];
    logic [2:0]  m_prev;
    logic [63:0] m_instret;
    logic        m_bad, m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    writeback_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .stage_i    (stage_i),
        .itype_i    (itype_i),
        .ir_i       (ir_i),
        .y_in       (y_in),
        .mem_i      (mem_i),
        .pc_i       (pc_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .wb_valid_o (wb_valid_o),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .instret_o  (instret_o),
        .bad_load_o (bad_load_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, 7'h13};
    endfunction

    // Result of one retiring instruction, written from the ISA rules.
    task automatic model_result(input logic [4:0] it, input logic [31:0] ir, y, mem, pc,
                                output bit wr, output bit bad, output logic [31:0] v);
        int unsigned b, h;
        wr = 1'b1; bad = 1'b0; v = 32'd0;
        b = mem % 256;
        h = mem % 65536;
        if (it == RTYPE || it == ITYPE || it == LUITYPE || it == AUIPCTYPE) v = y;
        else if (it == JALTYPE || it == JALRTYPE) v = pc + 32'd4;
        else if (it == LTYPE) begin
            case (int'(ir[14:12]))
                0: v = (b >= 128) ? b - 256 : b;
                1: v = (h >= 32768) ? h - 65536 : h;
                2: v = mem;
                4: v = b;
                5: v = h;
                default: begin wr = 1'b0; bad = 1'b1; end
            endcase
        end else wr = 1'b0;
    endtask

    task automatic model_edge();
        bit wr, bad;
        logic [31:0] v;
        logic [4:0] rd;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_prev = 3'd0; m_instret = 64'd0; m_bad = 1'b0;
            m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0;
        end else begin
            m_valid = 1'b0;
            if (stage_i == 3'd5 && m_prev != 3'd5) begin
                m_instret = m_instret + 64'd1;
                model_result(itype_i, ir_i, y_in, mem_i, pc_i, wr, bad, v);
                rd = ir_i[11:7];
                if (bad) m_bad = 1'b1;
                if (wr && rd != 5'd0) begin
                    m_regs[rd] = v; m_valid = 1'b1; m_rd = rd; m_data = v;
                end
            end
            m_prev = stage_i;
        end
    endtask

    task automatic check_all();
        chk("rs1_o", rs1_o, m_regs[rs1_addr_i]);
        chk("rs2_o", rs2_o, m_regs[rs2_addr_i]);
        chk("wb_valid_o", wb_valid_o, m_valid);
        chk("wb_rd_o", wb_rd_o, m_rd);
        chk("wb_data_o", wb_data_o, m_data);
        chk("instret_o", instret_o, m_instret);
        chk("bad_load_o", bad_load_o, m_bad);
    endtask

    task automatic cycle(input logic rst, input logic [2:0] st, input logic [4:0] it,
                         input logic [31:0] ir, y, mem, pc);
        reset = rst; stage_i = st; itype_i = it; ir_i = ir;
        y_in = y; mem_i = mem; pc_i = pc;
        rs1_addr_i = 5'($urandom_range(0, 31));
        rs2_addr_i = 5'($urandom_range(0, 31));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic instr(input logic [4:0] it, input logic [31:0] ir, y, mem, pc);
        cycle(1'b0, 3'd4, it, ir, y, mem, pc);
        cycle(1'b0, 3'd5, it, ir, y, mem, pc);
    endtask

    task automatic read_a(input logic [4:0] a);
        rs1_addr_i = a;
        #1;
    endtask

    initial begin
        logic [63:0] ir_before;
        int pulses;
        logic [2:0] st;

        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_prev = 3'd0; m_instret = 64'd0; m_bad = 1'b0;
        m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0;

        cycle(1'b1, 3'd0, RTYPE, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle(1'b1, 3'd0, RTYPE, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("reset_instret", instret_o, 64'd0);
        chk("reset_wb_valid", wb_valid_o, 64'd0);

        // reset on the commit cycle
        instr(RTYPE, mk_ir(5'd5, 3'd0), 32'h0000_1234, 32'd0, 32'd0);
        read_a(5'd5);
        chk("x5_written", rs1_o, 32'h0000_1234);
        cycle(1'b0, 3'd4, RTYPE, mk_ir(5'd5, 3'd0), 32'h5555_5555, 32'd0, 32'd0);
        cycle(1'b1, 3'd5, RTYPE, mk_ir(5'd5, 3'd0), 32'h5555_5555, 32'd0, 32'd0);
        chk("rst_commit_valid", wb_valid_o, 64'd0);
        chk("rst_commit_data", wb_data_o, 64'd0);
        chk("rst_commit_instret", instret_o, 64'd0);
        cycle(1'b0, 3'd0, RTYPE, 32'd0, 32'd0, 32'd0, 32'd0);
        read_a(5'd5);
        chk("x5_after_reset", rs1_o, 32'd0);

        // sub-word loads
        instr(LTYPE, mk_ir(5'd3, LB3), 32'd0, 32'h0000_0080, 32'd0);
        read_a(5'd3);
        chk("lb_sign", rs1_o, 32'hFFFF_FF80);
        chk("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
        instr(LTYPE, mk_ir(5'd3, LBU3), 32'd0, 32'h0000_0080, 32'd0);
        read_a(5'd3);
        chk("lbu_zero", rs1_o, 32'h0000_0080);
        instr(LTYPE, mk_ir(5'd4, LH3), 32'd0, 32'h0000_8001, 32'd0);
        read_a(5'd4);
        chk("lh_sign", rs1_o, 32'hFFFF_8001);

        // rd = 0 then rd = 7
        ir_before = instret_o;
        instr(RTYPE, mk_ir(5'd0, 3'd0), 32'hDEAD_BEEF, 32'd0, 32'd0);
        read_a(5'd0);
        chk("rd0_valid", wb_valid_o, 64'd0);
        chk("rd0_read", rs1_o, 32'd0);
        chk("rd0_instret", instret_o, ir_before + 64'd1);
        instr(RTYPE, mk_ir(5'd7, 3'd0), 32'hDEAD_BEEF, 32'd0, 32'd0);
        read_a(5'd7);
        chk("x7", rs1_o, 32'hDEAD_BEEF);

        // link wrap and store
        instr(JALTYPE, mk_ir(5'd1, 3'd0), 32'd0, 32'd0, 32'hFFFF_FFFC);
        read_a(5'd1);
        chk("jal_wrap", rs1_o, 32'h0000_0000);
        chk("jal_valid", wb_valid_o, 64'd1);
        ir_before = instret_o;
        instr(STYPE, mk_ir(5'd7, 3'd2), 32'h1111_1111, 32'd0, 32'd0);
        read_a(5'd7);
        chk("store_nowrite", rs1_o, 32'hDEAD_BEEF);
        chk("store_instret", instret_o, ir_before + 64'd1);

        // dwell in WB
        ir_before = instret_o;
        pulses = 0;
        cycle(1'b0, 3'd4, RTYPE, mk_ir(5'd9, 3'd0), 32'h0BAD_F00D, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd5, RTYPE, mk_ir(5'd9, 3'd0), 32'h0BAD_F00D, 32'd0, 32'd0);
            if (wb_valid_o) pulses++;
        end
        chk("dwell_pulses", 64'(pulses), 64'd1);
        chk("dwell_instret", instret_o, ir_before + 64'd1);

        // illegal load
        instr(LTYPE, mk_ir(5'd10, 3'd3), 32'd0, 32'h1234_5678, 32'd0);
        read_a(5'd10);
        chk("bad_load_set", bad_load_o, 64'd1);
        chk("bad_load_nowrite", rs1_o, 32'd0);
        instr(RTYPE, mk_ir(5'd11, 3'd0), 32'h0000_0011, 32'd0, 32'd0);
        chk("bad_load_sticky", bad_load_o, 64'd1);
        cycle(1'b1, 3'd0, RTYPE, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("bad_load_clear", bad_load_o, 64'd0);

        // random traffic
        st = 3'd0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) < 7) st = (st == 3'd5) ? 3'd1 : st + 3'd1;
            else if ($urandom_range(0, 3) == 0) st = 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 199) == 0), st, 5'($urandom_range(0, 10)),
                  $urandom, $urandom, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
